// File: rtl/ex_result_queue_if.sv
// Bundles the ALU-side push bus, the writeback-side pop bus and the one-cycle
// redirect/exception reports of the execute-stage result queue.
interface ex_result_queue_if #(
  parameter int EXC_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc;
  logic [31:0]      in_result;
  logic             in_wen;
  logic [4:0]       in_dest;
  logic [34:0]      in_other;
  logic             in_is_branch;
  logic [EXC_W-1:0] in_excode;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_result;
  logic             out_wen;
  logic [4:0]       out_dest;

  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             exc_valid;
  logic [31:0]      exc_pc;
  logic [EXC_W-1:0] exc_code;

  modport slave (
    input  in_valid, in_pc, in_result, in_wen, in_dest, in_other, in_is_branch, in_excode,
    input  out_ready,
    output in_ready,
    output out_valid, out_pc, out_result, out_wen, out_dest,
    output redirect_valid, redirect_pc, exc_valid, exc_pc, exc_code
  );

  modport master (
    output in_valid, in_pc, in_result, in_wen, in_dest, in_other, in_is_branch, in_excode,
    output out_ready,
    input  in_ready,
    input  out_valid, out_pc, out_result, out_wen, out_dest,
    input  redirect_valid, redirect_pc, exc_valid, exc_pc, exc_code
  );
endinterface

// File: rtl/ex_result_queue.sv
// Execute-stage result FIFO: buffers ALU results for writeback, emits a fetch
// redirect on mispredicted branches and reports exceptions after draining.
module ex_result_queue #(
  parameter int               DEPTH  = 2,
  parameter int               EXC_W  = 5,
  parameter logic [EXC_W-1:0] E_NONE = '0
) (
  input  logic           clk,
  input  logic           resetn,
  ex_result_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {RUN, EXC_DRAIN, EXC_REPORT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic        wen;
    logic [4:0]  dest;
  } entry_t;

  state_t           state_q, state_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [31:0]      exc_pc_q, exc_pc_d;
  logic [EXC_W-1:0] exc_code_q, exc_code_d;

  logic has_exc, push, pop, in_ready;
  logic unused_other;

  assign unused_other = bus.in_other[34];
  assign has_exc  = bus.in_excode != E_NONE;
  // A full queue still accepts when the head leaves in the same cycle.
  assign in_ready = (state_q == RUN) &&
                    ((count_q != CNT_W'(DEPTH)) || bus.out_ready);
  assign push     = bus.in_valid && in_ready;
  assign pop      = (count_q != '0) && bus.out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q].pc     = bus.in_pc;
      mem_d[wr_ptr_q].result = bus.in_result;
      mem_d[wr_ptr_q].wen    = bus.in_wen && !has_exc;
      mem_d[wr_ptr_q].dest   = bus.in_dest;
      wr_ptr_d               = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // An excepting branch never redirects; the exception path owns the restart.
  always_comb begin
    redirect_valid_d = push && bus.in_is_branch && bus.in_other[33] && !has_exc;
    redirect_pc_d    = redirect_pc_q;
    if (redirect_valid_d) begin
      redirect_pc_d = bus.in_other[32] ? bus.in_other[31:0] : bus.in_pc + 32'd8;
    end
  end

  always_comb begin
    state_d    = state_q;
    exc_pc_d   = exc_pc_q;
    exc_code_d = exc_code_q;
    case (state_q)
      RUN: begin
        if (push && has_exc) begin
          state_d    = EXC_DRAIN;
          exc_pc_d   = bus.in_pc;
          exc_code_d = bus.in_excode;
        end
      end
      EXC_DRAIN: begin
        if (count_q == '0) state_d = EXC_REPORT;
      end
      EXC_REPORT: state_d = RUN;
      default:    state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= RUN;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      exc_pc_q         <= '0;
      exc_code_q       <= E_NONE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      exc_pc_q         <= exc_pc_d;
      exc_code_q       <= exc_code_d;
      mem_q            <= mem_d;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = count_q != '0;
  assign bus.out_pc         = mem_q[rd_ptr_q].pc;
  assign bus.out_result     = mem_q[rd_ptr_q].result;
  assign bus.out_wen        = mem_q[rd_ptr_q].wen;
  assign bus.out_dest       = mem_q[rd_ptr_q].dest;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.exc_valid      = state_q == EXC_REPORT;
  assign bus.exc_pc         = exc_pc_q;
  assign bus.exc_code       = exc_code_q;
endmodule
